id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS core.
- Captures decoded control, register operands, sign-extended immediate and register addresses at the end of ID, and presents them to EX.
- Feeds ALUOp/funct into the ALU control decoder and operands into the ALU.
- Supports load-use stall (hold), branch/jump flush (bubble insertion), and a registered jump-register flag.

---
 rtl/id_ex_pipe_reg.sv | 141 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: stall holds, flush or an invalid decode writes a bubble, jr is detected on load.
// Optional ID_EX_PERF_CNT_EN adds saturating bubble/stall counters; otherwise both counters read 0.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_op,
  output logic [5:0]        ex_funct,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_jr,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              reg_dst;
    logic              jr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
  } ex_bus_t;

  ex_bus_t r_ex;
  ex_bus_t w_id;
  logic    w_bubble;
  logic    w_stall;

  // An invalid decode on a load edge is treated as a bubble so EX never sees stray control.
  assign w_bubble = flush | (~stall & ~id_valid);
  assign w_stall  = stall & ~flush;

  always_comb begin
    w_id            = '0;
    w_id.valid      = id_valid;
    w_id.alu_op     = id_alu_op;
    w_id.funct      = id_funct;
    w_id.reg_write  = id_reg_write;
    w_id.mem_read   = id_mem_read;
    w_id.mem_write  = id_mem_write;
    w_id.mem_to_reg = id_mem_to_reg;
    w_id.alu_src    = id_alu_src;
    w_id.reg_dst    = id_reg_dst;
    w_id.jr         = id_valid & ({id_alu_op, id_funct} == 8'b00_001000);
    w_id.rs_data    = id_rs_data;
    w_id.rt_data    = id_rt_data;
    w_id.imm        = id_imm;
    w_id.rs         = id_rs;
    w_id.rt         = id_rt;
    w_id.rd         = id_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ex <= '0;
    else if (w_bubble) r_ex <= '0;
    else if (!stall)   r_ex <= w_id;
  end

  assign ex_valid      = r_ex.valid;
  assign ex_alu_op     = r_ex.alu_op;
  assign ex_funct      = r_ex.funct;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;
  assign ex_mem_to_reg = r_ex.mem_to_reg;
  assign ex_alu_src    = r_ex.alu_src;
  assign ex_reg_dst    = r_ex.reg_dst;
  assign ex_jr         = r_ex.jr;
  assign ex_rs_data    = r_ex.rs_data;
  assign ex_rt_data    = r_ex.rt_data;
  assign ex_imm        = r_ex.imm;
  assign ex_rs         = r_ex.rs;
  assign ex_rt         = r_ex.rt;
  assign ex_rd         = r_ex.rd;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_stall  && (r_stall_cnt  != 32'hFFFF_FFFF)) r_stall_cnt  <= r_stall_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;
`else
  logic w_unused;
  assign w_unused   = w_stall;
  assign bubble_cnt = 32'd0;
  assign stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed, table-driven bench for id_ex_pipe_reg: one table row per clock edge, plus async-reset sequences.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, id_valid;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_valid;
  logic [1:0]  ex_alu_op;
  logic [5:0]  ex_funct;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_jr;
  logic [31:0] bubble_cnt, stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_jr(ex_jr),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  // One row per edge. Secondary inputs are tied to primary ones so they can be checked too:
  // mem_read = mem_to_reg = mw, alu_src = reg_dst = rw, imm = rsd + rtd, rs = rt = rd.
  typedef struct {
    logic        stall, flush, vld;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic        rw, mw;
    logic [31:0] rsd, rtd;
    logic [4:0]  rd;
    logic        x_vld, x_jr, x_rw, x_mw;
    logic [1:0]  x_op;
    logic [5:0]  x_fn;
    logic [31:0] x_rsd, x_rtd;
    logic [4:0]  x_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic fl, logic vld, logic [1:0] op, logic [5:0] fn,
                              logic rw, logic mw, logic [31:0] rsd, logic [31:0] rtd, logic [4:0] rd,
                              logic x_vld, logic x_jr, logic [1:0] x_op, logic [5:0] x_fn,
                              logic x_rw, logic x_mw, logic [31:0] x_rsd, logic [31:0] x_rtd,
                              logic [4:0] x_rd);
    vec_t v;
    v.stall = st; v.flush = fl; v.vld = vld; v.op = op; v.fn = fn; v.rw = rw; v.mw = mw;
    v.rsd = rsd; v.rtd = rtd; v.rd = rd;
    v.x_vld = x_vld; v.x_jr = x_jr; v.x_op = x_op; v.x_fn = x_fn; v.x_rw = x_rw; v.x_mw = x_mw;
    v.x_rsd = x_rsd; v.x_rtd = x_rtd; v.x_rd = x_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; flush = v.flush; id_valid = v.vld;
    id_alu_op = v.op; id_funct = v.fn;
    id_reg_write = v.rw; id_alu_src = v.rw; id_reg_dst = v.rw;
    id_mem_write = v.mw; id_mem_read = v.mw; id_mem_to_reg = v.mw;
    id_rs_data = v.rsd; id_rt_data = v.rtd; id_imm = v.rsd + v.rtd;
    id_rs = v.rd; id_rt = v.rd; id_rd = v.rd;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_ctrl"}, {22'd0, ex_alu_op, ex_funct, ex_reg_write, ex_mem_read}, 32'd0);
    chk({tag, "_ctrl2"}, {28'd0, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst}, 32'd0);
    chk({tag, "_jr"}, {31'd0, ex_jr}, 32'd0);
    chk({tag, "_rs_data"}, ex_rs_data, 32'd0);
    chk({tag, "_rt_data"}, ex_rt_data, 32'd0);
    chk({tag, "_imm"}, ex_imm, 32'd0);
    chk({tag, "_addr"}, {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
    chk({tag, "_bubble_cnt"}, bubble_cnt, 32'd0);
    chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
  endtask

  initial begin
    // Row order: reset-release load, stall over 3 edges, flush priority, jr cases, back-to-back.
    vecs.push_back(mk(0,0,1, 2'b10,6'h20, 1,0, 32'h5,32'h0,5'd0,   1,0,2'b10,6'h20,1,0,32'h5,32'h0,5'd0));
    vecs.push_back(mk(0,0,1, 2'b00,6'h00, 0,1, 32'h7,32'h3,5'd9,   1,0,2'b00,6'h00,0,1,32'h7,32'h3,5'd9));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,0,1, 2'b10,6'h22, 1,0, 32'h11,32'h22,5'd3, 1,0,2'b00,6'h00,0,1,32'h7,32'h3,5'd9));
    vecs.push_back(mk(0,0,1, 2'b10,6'h22, 1,0, 32'h11,32'h22,5'd3, 1,0,2'b10,6'h22,1,0,32'h11,32'h22,5'd3));
    vecs.push_back(mk(0,0,1, 2'b00,6'h00, 0,1, 32'hAA,32'hBB,5'd4, 1,0,2'b00,6'h00,0,1,32'hAA,32'hBB,5'd4));
    vecs.push_back(mk(1,1,1, 2'b10,6'h20, 1,1, 32'hCC,32'hDD,5'd7, 0,0,2'b00,6'h00,0,0,32'h0,32'h0,5'd0));
    vecs.push_back(mk(0,0,1, 2'b00,6'h08, 0,0, 32'h40,32'h0,5'd0,  1,1,2'b00,6'h08,0,0,32'h40,32'h0,5'd0));
    vecs.push_back(mk(0,0,0, 2'b00,6'h08, 1,1, 32'h40,32'h1,5'd2,  0,0,2'b00,6'h00,0,0,32'h0,32'h0,5'd0));
    vecs.push_back(mk(0,0,1, 2'b00,6'h09, 1,0, 32'h44,32'h0,5'd31, 1,0,2'b00,6'h09,1,0,32'h44,32'h0,5'd31));
    vecs.push_back(mk(0,1,1, 2'b01,6'h00, 1,1, 32'h55,32'h66,5'd8, 0,0,2'b00,6'h00,0,0,32'h0,32'h0,5'd0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0,0,1, 2'b10,6'h20, 1,0, 32'h100,i,5'(i), 1,0,2'b10,6'h20,1,0,32'h100,i,5'(i)));

    drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[k]) begin
      drive(vecs[k]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", k), {31'd0, ex_valid}, {31'd0, vecs[k].x_vld});
      chk($sformatf("v%0d_jr", k), {31'd0, ex_jr}, {31'd0, vecs[k].x_jr});
      chk($sformatf("v%0d_op_fn", k), {24'd0, ex_alu_op, ex_funct}, {24'd0, vecs[k].x_op, vecs[k].x_fn});
      chk($sformatf("v%0d_ctrl", k),
          {26'd0, ex_reg_write, ex_alu_src, ex_reg_dst, ex_mem_write, ex_mem_read, ex_mem_to_reg},
          {26'd0, vecs[k].x_rw, vecs[k].x_rw, vecs[k].x_rw, vecs[k].x_mw, vecs[k].x_mw, vecs[k].x_mw});
      chk($sformatf("v%0d_rs_data", k), ex_rs_data, vecs[k].x_rsd);
      chk($sformatf("v%0d_rt_data", k), ex_rt_data, vecs[k].x_rtd);
      chk($sformatf("v%0d_imm", k), ex_imm, vecs[k].x_rsd + vecs[k].x_rtd);
      chk($sformatf("v%0d_addr", k), {17'd0, ex_rs, ex_rt, ex_rd},
          {17'd0, vecs[k].x_rd, vecs[k].x_rd, vecs[k].x_rd});
`ifndef ID_EX_PERF_CNT_EN
      chk($sformatf("v%0d_cnt_off", k), bubble_cnt | stall_cnt, 32'd0);
`endif
      @(negedge clk);
    end

`ifdef ID_EX_PERF_CNT_EN
    // Bubbles: stall+flush row, invalid-jr row, plain flush row. Stalls: three held edges only.
    chk("bubble_cnt", bubble_cnt, 32'd3);
    chk("stall_cnt", stall_cnt, 32'd3);
`endif

    // Asynchronous reset in the middle of a stall clears everything before any edge.
    drive(mk(1,0,1, 2'b10,6'h20, 1,1, 32'h77,32'h88,5'd6, 0,0,0,0,0,0,0,0,0));
    chk("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_mid_stall");

    // Release, load one instruction, then reset in the middle of a flush.
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0,0,1, 2'b00,6'h08, 0,0, 32'h99,32'h0,5'd12, 0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    chk("post_reset_jr", {31'd0, ex_jr}, 32'd1);
    chk("post_reset_rs_data", ex_rs_data, 32'h99);
    @(negedge clk);
    flush = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_mid_flush");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
